hazard_scoreboard: RTL and testbench

Parametrised successor to the combinational ID-stage hazard check. It keeps a per-register countdown scoreboard of in-flight writes, so each instruction can carry its own write latency (ALU, load, multi-cycle multiply). It supports stall-only and forwarding-aware modes and detects WAW ordering hazards. It sits beside the ID stage: it drives the active-low `pipeline_stall_n` that freezes IF/ID and bubbles EX, and records each issued instruction's destination.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_reg_counter.sv | 39 +++
 rtl/hazard_scoreboard.sv | 99 +++++++++
 tb/tb_hazard_scoreboard.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared defaults, typedefs and latency clamp for the hazard scoreboard
package hazard_pkg;

  localparam int DEF_REG_W   = 3;
  localparam int DEF_MAX_LAT = 3;
  localparam int DEF_LAT_W   = 2;

  typedef logic [DEF_REG_W-1:0] reg_num_t;
  typedef logic [DEF_LAT_W-1:0] lat_t;

  // Clamp a requested write latency into 1..max_lat; zero means "next cycle".
  function automatic int eff_lat(input int dest_lat, input int max_lat = DEF_MAX_LAT);
    if (dest_lat < 1) return 1;
    if (dest_lat > max_lat) return max_lat;
    return dest_lat;
  endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// rtl/hazard_reg_counter.sv - per-register countdown of cycles until a pending write is readable
module hazard_reg_counter
  import hazard_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  // A new write overrides the countdown; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  // Counter register; reset discards the pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage RAW/WAW hazard scoreboard driving the active-low pipeline stall
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = DEF_REG_W,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int LAT_W    = DEF_LAT_W,
  parameter int FWD_EN   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [NUM_SRC*REG_W-1:0] src_reg,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic                     dest_we,
  input  logic [REG_W-1:0]         dest_reg,
  input  logic [LAT_W-1:0]         dest_lat,
  output logic                     pipeline_stall_n,
  output logic [NUM_SRC-1:0]       stall_src,
  output logic                     stall_waw,
  output logic [15:0]              stall_cycles
);

  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic [LAT_W-1:0]    lat_eff;
  logic [REG_W-1:0]    src_sel;
  logic                stall;
  logic                accept;
  logic [15:0]         stall_cycles_q, stall_cycles_d;

  // Register zero is hard-wired and never has a pending write.
  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic load_r;
    assign load_r = accept && dest_we && (dest_reg == REG_W'(r));
    hazard_reg_counter #(
      .LAT_W(LAT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load_r),
      .load_val (lat_eff),
      .cnt      (cnt[r]),
      .busy     (busy_vec[r])
    );
  end

  // Clamp latency before it is used in the WAW compare and in the counter load.
  always_comb begin
    lat_eff = LAT_W'(eff_lat(int'(dest_lat), MAX_LAT));
  end

  // RAW check per source against the pre-update counters; with forwarding a
  // result is usable once its counter has reached 1.
  always_comb begin
    stall_src = '0;
    src_sel   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_sel = src_reg[i*REG_W +: REG_W];
      if (!rst && issue_valid && src_used[i] && (src_sel != '0)) begin
        stall_src[i] = (FWD_EN != 0) ? (cnt[src_sel] > LAT_W'(1)) : busy_vec[src_sel];
      end
    end
  end

  // WAW: a new write must not retire ahead of an older write to the same register.
  always_comb begin
    stall_waw = !rst && issue_valid && dest_we && (dest_reg != '0) && (cnt[dest_reg] > lat_eff);
  end

  assign stall            = (|stall_src) || stall_waw;
  assign pipeline_stall_n = !stall;
  assign accept           = issue_valid && !stall && !rst;

  // Saturating count of cycles in which a valid instruction was held back.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        issue_valid;
  logic [5:0]  src_reg;
  logic [1:0]  src_used;
  logic        dest_we;
  logic [2:0]  dest_reg;
  logic [1:0]  dest_lat;

  logic        stall_n0, stall_n1;
  logic [1:0]  ssrc0, ssrc1;
  logic        waw0, waw1;
  logic [15:0] sc0, sc1;

  logic        s_valid;
  logic [5:0]  s_src;
  logic [1:0]  s_used;
  logic        s_we;
  logic [2:0]  s_dst;
  logic [3:0]  s_lat;
  logic        s_stall_n;
  logic [1:0]  s_ssrc;
  logic        s_waw;
  logic [15:0] s_sc;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard #(.NUM_REGS(8), .REG_W(3), .NUM_SRC(2), .MAX_LAT(3), .LAT_W(2), .FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src_reg(src_reg), .src_used(src_used),
    .dest_we(dest_we), .dest_reg(dest_reg), .dest_lat(dest_lat),
    .pipeline_stall_n(stall_n0), .stall_src(ssrc0), .stall_waw(waw0), .stall_cycles(sc0)
  );

  hazard_scoreboard #(.NUM_REGS(8), .REG_W(3), .NUM_SRC(2), .MAX_LAT(3), .LAT_W(2), .FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src_reg(src_reg), .src_used(src_used),
    .dest_we(dest_we), .dest_reg(dest_reg), .dest_lat(dest_lat),
    .pipeline_stall_n(stall_n1), .stall_src(ssrc1), .stall_waw(waw1), .stall_cycles(sc1)
  );

  hazard_scoreboard #(.NUM_REGS(8), .REG_W(3), .NUM_SRC(2), .MAX_LAT(14), .LAT_W(4), .FWD_EN(0)) u_sat (
    .clk(clk), .rst(rst), .issue_valid(s_valid), .src_reg(s_src), .src_used(s_used),
    .dest_we(s_we), .dest_reg(s_dst), .dest_lat(s_lat),
    .pipeline_stall_n(s_stall_n), .stall_src(s_ssrc), .stall_waw(s_waw), .stall_cycles(s_sc)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used,
                       input logic we, input logic [2:0] d, input logic [1:0] lat);
    @(negedge clk);
    issue_valid = v;
    src_reg     = {s1, s0};
    src_used    = used;
    dest_we     = we;
    dest_reg    = d;
    dest_lat    = lat;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 3'd0, 2'd0);
  endtask

  logic       exp_n0_a [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       exp_n1_a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       exp_waw_e [3] = '{1'b1, 1'b1, 1'b0};
  logic [1:0] lat_b [2] = '{2'd1, 2'd0};

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_src = '0; s_used = '0; s_we = 1'b0; s_dst = '0; s_lat = '0;
    idle(2);
    check_eq("reset_stall_n", {31'd0, stall_n0}, 1);
    check_eq("reset_stall_cycles", {16'd0, sc0}, 0);
    rst = 1'b0;

    // RAW back-to-back, latency 3
    issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 3'd2, 2'd3);
    check_eq("raw_producer_accept", {31'd0, stall_n0}, 1);
    for (int c = 0; c < 4; c++) begin
      issue(1'b1, 3'd2, 3'd1, 2'b11, 1'b1, 3'd4, 2'd1);
      check_eq($sformatf("raw_nofwd_stall_n_c%0d", c), {31'd0, stall_n0}, {31'd0, exp_n0_a[c]});
      check_eq($sformatf("raw_nofwd_src_c%0d", c), {30'd0, ssrc0}, exp_n0_a[c] ? 32'd0 : 32'd1);
      check_eq($sformatf("raw_fwd_stall_n_c%0d", c), {31'd0, stall_n1}, {31'd0, exp_n1_a[c]});
    end
    idle(4);
    check_eq("raw_nofwd_stall_cycles", {16'd0, sc0}, 3);
    check_eq("raw_fwd_stall_cycles", {16'd0, sc1}, 2);

    // Latency 1 and latency 0 (treated as 1)
    for (int j = 0; j < 2; j++) begin
      issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 3'd2, lat_b[j]);
      issue(1'b1, 3'd2, 3'd0, 2'b01, 1'b0, 3'd0, 2'd0);
      check_eq($sformatf("lat%0d_nofwd_stall_n", lat_b[j]), {31'd0, stall_n0}, 0);
      check_eq($sformatf("lat%0d_fwd_stall_n", lat_b[j]), {31'd0, stall_n1}, 1);
      check_eq($sformatf("lat%0d_fwd_src", lat_b[j]), {30'd0, ssrc1}, 0);
      issue(1'b1, 3'd2, 3'd0, 2'b01, 1'b0, 3'd0, 2'd0);
      check_eq($sformatf("lat%0d_nofwd_release", lat_b[j]), {31'd0, stall_n0}, 1);
      idle(2);
    end
    check_eq("lat_nofwd_stall_cycles", {16'd0, sc0}, 5);
    check_eq("lat_fwd_stall_cycles", {16'd0, sc1}, 2);

    // Register zero is never tracked
    issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 3'd0, 2'd3);
    check_eq("r0_write_stall_n", {31'd0, stall_n0}, 1);
    issue(1'b1, 3'd0, 3'd0, 2'b11, 1'b1, 3'd0, 2'd1);
    check_eq("r0_read_nofwd_stall_n", {31'd0, stall_n0}, 1);
    check_eq("r0_read_fwd_stall_n", {31'd0, stall_n1}, 1);
    check_eq("r0_read_waw", {31'd0, waw0}, 0);

    // src_used masking
    issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 3'd5, 2'd3);
    issue(1'b1, 3'd1, 3'd5, 2'b11, 1'b1, 3'd6, 2'd1);
    check_eq("mask_used11_nofwd_src", {30'd0, ssrc0}, 2);
    check_eq("mask_used11_fwd_src", {30'd0, ssrc1}, 2);
    issue(1'b1, 3'd1, 3'd5, 2'b01, 1'b1, 3'd6, 2'd1);
    check_eq("mask_used01_nofwd_stall_n", {31'd0, stall_n0}, 1);
    check_eq("mask_used01_fwd_stall_n", {31'd0, stall_n1}, 1);
    idle(4);
    check_eq("mask_nofwd_stall_cycles", {16'd0, sc0}, 6);
    check_eq("mask_fwd_stall_cycles", {16'd0, sc1}, 3);

    // WAW ordering: r3 lat 3 then r3 lat 1
    issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 3'd3, 2'd3);
    for (int c = 0; c < 3; c++) begin
      issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 3'd3, 2'd1);
      check_eq($sformatf("waw_nofwd_c%0d", c), {31'd0, waw0}, {31'd0, exp_waw_e[c]});
      check_eq($sformatf("waw_fwd_c%0d", c), {31'd0, waw1}, {31'd0, exp_waw_e[c]});
      check_eq($sformatf("waw_stall_n_c%0d", c), {31'd0, stall_n0}, {31'd0, !exp_waw_e[c]});
    end
    issue(1'b1, 3'd3, 3'd0, 2'b01, 1'b0, 3'd0, 2'd0);
    check_eq("waw_reload_nofwd_stall_n", {31'd0, stall_n0}, 0);
    check_eq("waw_reload_fwd_stall_n", {31'd0, stall_n1}, 1);
    issue(1'b1, 3'd3, 3'd0, 2'b01, 1'b0, 3'd0, 2'd0);
    check_eq("waw_reload_nofwd_release", {31'd0, stall_n0}, 1);
    idle(3);
    check_eq("waw_nofwd_stall_cycles", {16'd0, sc0}, 9);
    check_eq("waw_fwd_stall_cycles", {16'd0, sc1}, 5);

    // Reset mid-operation while cnt[2] = 2
    issue(1'b1, 3'd0, 3'd0, 2'b00, 1'b1, 3'd2, 2'd3);
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    issue_valid = 1'b1; src_reg = {3'd0, 3'd2}; src_used = 2'b01; dest_we = 1'b1; dest_reg = 3'd2; dest_lat = 2'd1;
    #1;
    check_eq("rst_forced_stall_n", {31'd0, stall_n0}, 1);
    check_eq("rst_forced_src", {30'd0, ssrc0}, 0);
    check_eq("rst_forced_waw", {31'd0, waw0}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_nofwd_stall_n", {31'd0, stall_n0}, 1);
    check_eq("post_rst_fwd_stall_n", {31'd0, stall_n1}, 1);
    check_eq("post_rst_stall_cycles", {16'd0, sc0}, 0);
    idle(3);

    // Saturation with a clamped latency of 15 -> 14 on a self-dependent instruction
    @(negedge clk);
    s_valid = 1'b1; s_src = {3'd0, 3'd2}; s_used = 2'b01; s_we = 1'b1; s_dst = 3'd2; s_lat = 4'd15;
    for (int c = 0; c < 72000; c++) begin
      #1;
      if (c == 1) check_eq("sat_first_stall_n", {31'd0, s_stall_n}, 0);
      if (c == 15) check_eq("sat_clamped_accept", {31'd0, s_stall_n}, 1);
      if (c == 16) check_eq("sat_count_after_16", {16'd0, s_sc}, 14);
      @(negedge clk);
    end
    #1;
    check_eq("sat_stall_cycles_max", {16'd0, s_sc}, 32'hFFFF);
    for (int c = 0; c < 20; c++) @(negedge clk);
    #1;
    check_eq("sat_stall_cycles_hold", {16'd0, s_sc}, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
